// File: rtl/pixie_scan_engine.sv
// Pixie-style display back end: raster timing, frame-buffer fetch, 1-bit serialiser
// and sync/blank/flag outputs, all aligned to a fixed 3-clock pipeline.
module pixie_scan_engine #(
  parameter int unsigned H_TOTAL       = 112,
  parameter int unsigned H_ACTIVE      = 64,
  parameter int unsigned H_SYNC_START  = 80,
  parameter int unsigned H_SYNC_WIDTH  = 12,
  parameter int unsigned PIXEL_REPEAT  = 1,
  parameter int unsigned V_TOTAL       = 262,
  parameter int unsigned V_ACTIVE      = 128,
  parameter int unsigned V_SYNC_START  = 200,
  parameter int unsigned V_SYNC_HEIGHT = 16,
  parameter int unsigned ADDR_W        = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        res_mode,
  input  logic              display_on,
  output logic              fb_read_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic              video,
  output logic              HSync,
  output logic              VSync,
  output logic              csync,
  output logic              HBlank,
  output logic              VBlank,
  output logic              video_de,
  output logic              efx,
  output logic              frame_start
);

  localparam int unsigned HW        = $clog2(H_TOTAL);
  localparam int unsigned VW        = $clog2(V_TOTAL);
  localparam int unsigned BYTE_CLKS = 8 * PIXEL_REPEAT;
  localparam int unsigned BPL       = H_ACTIVE / BYTE_CLKS;
  localparam int unsigned AW2       = ADDR_W + 2;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic csync;
    logic hblank;
    logic vblank;
    logic de;
    logic efx;
    logic fstart;
    logic don;
    logic fetch;
    logic tick;
  } align_t;

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [1:0]     mode_lat;
  logic           don_lat;
  logic           h_last_c;
  logic           v_last_c;
  logic [31:0]    hv_c;
  logic [31:0]    vv_c;
  logic           hact_c;
  logic           vact_c;
  logic [VW-1:0]  row_c;
  logic [AW2-1:0] addr_c;
  align_t         align_c;
  align_t         p1;
  align_t         p2;
  logic [7:0]     shifter;
  logic [7:0]     shifter_c;

  // Raster counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last_c) begin
      h_cnt <= '0;
      v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // display_on takes effect per line, resolution mode per frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_lat <= 2'd0;
      don_lat  <= 1'b0;
    end else begin
      if (h_last_c) don_lat <= display_on;
      if (h_last_c && v_last_c) mode_lat <= (res_mode == 2'd3) ? 2'd1 : res_mode;
    end
  end

  // Position decode for the current counter value
  always_comb begin
    h_last_c = (h_cnt == HW'(H_TOTAL - 1));
    v_last_c = (v_cnt == VW'(V_TOTAL - 1));
    hv_c     = 32'(h_cnt);
    vv_c     = 32'(v_cnt);
    hact_c   = (hv_c < H_ACTIVE);
    vact_c   = (vv_c < V_ACTIVE);
    row_c    = v_cnt >> mode_lat;
    addr_c   = AW2'(row_c) * AW2'(BPL) + AW2'(hv_c / BYTE_CLKS);

    align_c        = '0;
    align_c.hsync  = (hv_c >= H_SYNC_START) && (hv_c < H_SYNC_START + H_SYNC_WIDTH);
    align_c.vsync  = (vv_c >= V_SYNC_START) && (vv_c < V_SYNC_START + V_SYNC_HEIGHT);
    align_c.csync  = align_c.hsync ^ align_c.vsync;
    align_c.hblank = !hact_c;
    align_c.vblank = !vact_c;
    align_c.de     = hact_c && vact_c;
    align_c.efx    = ((vv_c >= V_ACTIVE - 4) && (vv_c < V_ACTIVE)) || (vv_c >= V_TOTAL - 4);
    align_c.fstart = (h_cnt == '0) && (v_cnt == '0);
    align_c.don    = don_lat;
    align_c.fetch  = hact_c && vact_c && don_lat && ((hv_c % BYTE_CLKS) == 0);
    align_c.tick   = ((hv_c % PIXEL_REPEAT) == 0);
  end

  // Byte load takes priority; otherwise shift once per pixel period
  always_comb begin
    shifter_c = shifter;
    if (p2.fetch) shifter_c = fb_data;
    else if (p2.tick) shifter_c = {shifter[6:0], 1'b0};
  end

  // Fetch stage plus the alignment pipeline feeding the registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1          <= '0;
      p2          <= '0;
      fb_read_en  <= 1'b0;
      fb_addr     <= '0;
      shifter     <= 8'd0;
      video       <= 1'b0;
      HSync       <= 1'b0;
      VSync       <= 1'b0;
      csync       <= 1'b0;
      HBlank      <= 1'b0;
      VBlank      <= 1'b0;
      video_de    <= 1'b0;
      efx         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      p1          <= align_c;
      p2          <= p1;
      fb_read_en  <= align_c.fetch;
      fb_addr     <= ADDR_W'(addr_c);
      shifter     <= shifter_c;
      video       <= shifter_c[7] & p2.de & p2.don;
      HSync       <= p2.hsync;
      VSync       <= p2.vsync;
      csync       <= p2.csync;
      HBlank      <= p2.hblank;
      VBlank      <= p2.vblank;
      video_de    <= p2.de;
      efx         <= p2.efx;
      frame_start <= p2.fstart;
    end
  end

endmodule

// File: tb/tb_pixie_scan_engine.sv
// Bench for pixie_scan_engine: raster-position model checked every clock, plus
// directed scenarios with hand-computed values and a pixel-repeat instance.
module tb_pixie_scan_engine;

  localparam int HT    = 112;
  localparam int HA    = 64;
  localparam int VT    = 262;
  localparam int VA    = 128;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic       fetch;
    logic [9:0] addr;
    logic       video;
    logic       hs;
    logic       vs;
    logic       cs;
    logic       hb;
    logic       vb;
    logic       de;
    logic       efx;
    logic       fs;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] res_mode = 2'd0;
  logic       display_on = 1'b1;
  logic       fb_read_en;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       video, HSync, VSync, csync, HBlank, VBlank, video_de, efx, frame_start;

  logic [1:0] res_mode2 = 2'd0;
  logic       display_on2 = 1'b1;
  logic       fb_read_en2;
  logic [9:0] fb_addr2;
  logic [7:0] fb_data2;
  logic       video2, hsync2, vsync2, csync2, hblank2, vblank2, de2, efx2, fs2;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [1024];
  logic       don_line [1024];
  int         mode_frame [8];
  int         k;

  always #5 clk = ~clk;

  pixie_scan_engine dut (
    .clk(clk), .reset_n(reset_n), .res_mode(res_mode), .display_on(display_on),
    .fb_read_en(fb_read_en), .fb_addr(fb_addr), .fb_data(fb_data), .video(video),
    .HSync(HSync), .VSync(VSync), .csync(csync), .HBlank(HBlank), .VBlank(VBlank),
    .video_de(video_de), .efx(efx), .frame_start(frame_start)
  );

  pixie_scan_engine #(
    .H_TOTAL(200), .H_ACTIVE(128), .H_SYNC_START(150), .H_SYNC_WIDTH(12), .PIXEL_REPEAT(2)
  ) dut_pr2 (
    .clk(clk), .reset_n(reset_n), .res_mode(res_mode2), .display_on(display_on2),
    .fb_read_en(fb_read_en2), .fb_addr(fb_addr2), .fb_data(fb_data2), .video(video2),
    .HSync(hsync2), .VSync(vsync2), .csync(csync2), .HBlank(hblank2), .VBlank(vblank2),
    .video_de(de2), .efx(efx2), .frame_start(fs2)
  );

  initial for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

  // Synchronous-read frame buffers
  always @(posedge clk) if (fb_read_en) fb_data <= mem[fb_addr];
  always @(posedge clk) if (fb_read_en2) fb_data2 <= 8'hA5;

  // Raster position since reset, with the line/frame latched settings it implies
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k             <= 0;
      don_line[0]   <= 1'b0;
      mode_frame[0] <= 0;
    end else begin
      if (k % HT == HT - 1) begin
        don_line[k / HT + 1] <= display_on;
        if ((k / HT) % VT == VT - 1)
          mode_frame[k / FRAME + 1] <= (res_mode == 2'd0) ? 0 : (res_mode == 2'd2) ? 2 : 1;
      end
      k <= k + 1;
    end
  end

  function automatic obs_t model_at(input int p);
    int h, ln, v, row, a;
    logic hact, vact, dn;
    logic [7:0] b;
    obs_t o;
    h    = p % HT;
    ln   = p / HT;
    v    = ln % VT;
    hact = (h < HA);
    vact = (v < VA);
    dn   = don_line[ln];
    row  = v >> mode_frame[ln / VT];
    a    = (row * (HA / 8) + h / 8) % 1024;
    b    = mem[a];
    o       = '0;
    o.hs    = (h >= 80) && (h < 92);
    o.vs    = (v >= 200) && (v < 216);
    o.cs    = o.hs ^ o.vs;
    o.hb    = !hact;
    o.vb    = !vact;
    o.de    = hact && vact;
    o.efx   = ((v >= VA - 4) && (v < VA)) || (v >= VT - 4);
    o.fs    = (h == 0) && (v == 0);
    o.fetch = o.de && dn && (h % 8 == 0);
    o.addr  = o.fetch ? 10'(a) : 10'd0;
    o.video = o.de && dn && b[7 - (h % 8)];
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic obs_t observed();
    observed = {fb_read_en, fb_read_en ? fb_addr : 10'd0, video, HSync, VSync, csync,
                HBlank, VBlank, video_de, efx, frame_start};
  endfunction

  task automatic compare_cycle();
    obs_t e, f;
    if (!reset_n) e = '0;
    else begin
      e = (k >= 3) ? model_at(k - 3) : obs_t'(0);
      f = (k >= 1) ? model_at(k - 1) : obs_t'(0);
      e.fetch = f.fetch;
      e.addr  = f.addr;
    end
    chk("cycle_model", 32'(observed()), 32'(e));
  endtask

  initial forever begin
    @(negedge clk);
    compare_cycle();
  end

  task automatic wait_state(input int target);
    int n = 0;
    while (k < target && n < 200000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_state", 32'(k), 32'(target));
  endtask

  task automatic measure_frame();
    int n = 0;
    int cde = 0, chs = 0, cvs = 0, ccs = 0, chb = 0, cvb = 0, cefx = 0, cfs = 0;
    @(negedge clk);
    while (!frame_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_frame_start", 32'(frame_start), 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      cde += int'(video_de); chs += int'(HSync); cvs += int'(VSync); ccs += int'(csync);
      chb += int'(HBlank); cvb += int'(VBlank); cefx += int'(efx); cfs += int'(frame_start);
      @(negedge clk);
    end
    chk("frame_period", 32'(frame_start), 32'd1);
    chk("frame_de_clocks", 32'(cde), 32'd8192);
    chk("frame_hsync_clocks", 32'(chs), 32'd3144);
    chk("frame_vsync_clocks", 32'(cvs), 32'd1792);
    chk("frame_csync_clocks", 32'(ccs), 32'd4552);
    chk("frame_hblank_clocks", 32'(chb), 32'd12576);
    chk("frame_vblank_clocks", 32'(cvb), 32'd15008);
    chk("frame_efx_clocks", 32'(cefx), 32'd896);
    chk("frame_start_count", 32'(cfs), 32'd1);
  endtask

  task automatic pr2_check();
    int n = 0;
    logic [15:0] bits = '0;
    int cde = 0, chs = 0, cvid = 0, chb = 0, cvb = 0, cvs = 0, ccs = 0, cefx = 0, cfs = 0, cfe = 0;
    logic [9:0] last_addr = '0;
    repeat (260) @(negedge clk);
    while (de2 && n < 400) begin @(negedge clk); n++; end
    n = 0;
    while (!de2 && n < 400) begin @(negedge clk); n++; end
    chk("pr2_de_rise", 32'(de2), 32'd1);
    for (int i = 0; i < 200; i++) begin
      if (i < 16) bits = {bits[14:0], video2};
      cde += int'(de2); chs += int'(hsync2); cvid += int'(video2); chb += int'(hblank2);
      cvb += int'(vblank2); cvs += int'(vsync2); ccs += int'(csync2); cefx += int'(efx2);
      cfs += int'(fs2);
      if (fb_read_en2) begin cfe++; last_addr = fb_addr2; end
      @(negedge clk);
    end
    chk("pr2_first_16_pixels", 32'(bits), 32'h0000CC33);
    chk("pr2_line_de", 32'(cde), 32'd128);
    chk("pr2_line_hsync", 32'(chs), 32'd12);
    chk("pr2_line_video_ones", 32'(cvid), 32'd64);
    chk("pr2_line_hblank", 32'(chb), 32'd72);
    chk("pr2_line_flags", 32'(cvb + cvs + cefx + cfs), 32'd0);
    chk("pr2_line_csync", 32'(ccs), 32'd12);
    chk("pr2_fetch_count", 32'(cfe), 32'd8);
    chk("pr2_last_addr", 32'(last_addr), 32'd24);
  endtask

  task automatic line5_mode2_check();
    int p = (VT + 5) * HT;
    logic [7:0] vb = '0;
    for (int s = p + 1; s <= p + 60; s++) begin
      int d;
      wait_state(s);
      d = s - p - 1;
      if (d % 8 == 0 && d <= 56) begin
        chk("l5_fetch", 32'(fb_read_en), 32'd1);
        chk("l5_addr", 32'(fb_addr), 32'(8 + d / 8));
      end
      if (s - p - 3 >= 8 && s - p - 3 <= 15) vb = {vb[6:0], video};
    end
    chk("l5_addr9_pixels", 32'(vb), 32'h09);
  endtask

  task automatic display_drop_check();
    int p10 = (2 * VT + 10) * HT;
    int p11 = p10 + HT;
    int cfe = 0, cvid = 0;
    wait_state(p10 + 30);
    display_on = 1'b0;
    wait_state(p10 + 42 + 3);
    chk("drop_line_continues", 32'(video), 32'd1);
    for (int s = p11 + 1; s <= p11 + 114; s++) begin
      wait_state(s);
      if (s <= p11 + HT) cfe += int'(fb_read_en);
      if (s >= p11 + 3) cvid += int'(video);
    end
    chk("off_line_fetches", 32'(cfe), 32'd0);
    chk("off_line_video", 32'(cvid), 32'd0);
    wait_state((2 * VT + 125) * HT + 5 + 3);
    chk("off_efx", 32'(efx), 32'd1);
    chk("off_de", 32'(video_de), 32'd1);
    chk("off_video", 32'(video), 32'd0);
    chk("off_hsync", 32'(HSync), 32'd0);
    chk("off_vblank", 32'(VBlank), 32'd0);
  endtask

  task automatic reset_check();
    int cfe = 0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    display_on = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs", 32'(observed()), 32'd0);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int s = 1; s <= HT + 1; s++) begin
      wait_state(s);
      if (s <= HT) cfe += int'(fb_read_en);
    end
    chk("post_reset_line0_fetches", 32'(cfe), 32'd0);
    chk("post_reset_first_fetch", 32'(fb_read_en), 32'd1);
    chk("post_reset_first_addr", 32'(fb_addr), 32'd8);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    res_mode   = 2'd2;
    display_on = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b1;
    fork
      measure_frame();
      pr2_check();
    join
    line5_mode2_check();
    wait_state((VT + 50) * HT + 20);
    res_mode = 2'd1;
    wait_state((VT + 60) * HT + 1);
    chk("mode_hold_fetch", 32'(fb_read_en), 32'd1);
    chk("mode_hold_addr", 32'(fb_addr), 32'd120);
    wait_state((2 * VT + 3) * HT + 1);
    chk("mode_new_fetch", 32'(fb_read_en), 32'd1);
    chk("mode_new_addr", 32'(fb_addr), 32'd8);
    display_drop_check();
    reset_check();
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
